// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: datapath widths used by the
// control unit, the instruction decoder and the program loader, the loader
// frame start marker, and the loader FSM state encoding.
package bip_pkg;

   localparam int         BIP_ADDR_W     = 11;
   localparam int         BIP_DATA_W     = 16;
   localparam logic [7:0] BIP_START_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_RUN,
      ST_HALT,
      ST_ERROR
   } loader_state_t;

endpackage

// File: rtl/program_ram.sv
// Program memory: one synchronous write port and one asynchronous read
// port, so the control unit sees the addressed instruction in the same cycle.
module program_ram
   import bip_pkg::*;
#(
   parameter int ADDR_W = BIP_ADDR_W,
   parameter int DATA_W = BIP_DATA_W,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port; contents are deliberately not reset so a program survives rst.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (start, length, words high
// byte first), writes the words into program memory, serves instructions to
// the control unit and enables the CPU only between a completed load and done.
module program_loader
   import bip_pkg::*;
#(
   parameter int         ADDR_W     = BIP_ADDR_W,
   parameter int         DATA_W     = BIP_DATA_W,
   parameter int         DEPTH      = 2 ** ADDR_W,
   parameter logic [7:0] START_BYTE = BIP_START_BYTE,
   parameter int         TIMEOUT    = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic [ADDR_W-1:0] i_prog_address,
   input  logic              i_bip_done,
   output logic [DATA_W-1:0] o_instruction,
   output logic              o_cpu_enable,
   output logic              o_loaded,
   output logic [ADDR_W:0]   o_word_count,
   output logic              o_error
);

   localparam int          CNT_W = $clog2(TIMEOUT + 1);
   localparam int          WC_W  = ADDR_W + 1;
   localparam logic [15:0] MAX_N = 16'(DEPTH);

   loader_state_t     r_state;
   logic              r_cpu_en;
   logic              r_loaded;
   logic [ADDR_W:0]   r_word_count;
   logic              r_error;
   logic [ADDR_W-1:0] r_waddr;
   logic [ADDR_W-1:0] r_last;
   logic [ADDR_W:0]   r_len_n;
   logic [7:0]        r_len_hi;
   logic [7:0]        r_hi;
   logic [CNT_W-1:0]  r_tmo;

   logic [15:0]       w_len;
   logic              w_in_frame;
   logic              w_timeout;
   logic              w_we;
   logic [DATA_W-1:0] w_wdata;

   assign w_len      = {r_len_hi, i_rx_data};
   assign w_in_frame = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                       (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO);
   // Fires on the cycle the gap reaches TIMEOUT; a byte arriving then still counts.
   assign w_timeout  = (r_tmo == CNT_W'(TIMEOUT - 1)) && !i_rx_valid;
   // Writing only in DATA_LO keeps memory frozen while the CPU is enabled.
   assign w_we       = (r_state == ST_DATA_LO) && i_rx_valid && !rst;
   assign w_wdata    = DATA_W'({r_hi, i_rx_data});

   program_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_waddr),
      .i_wdata (w_wdata),
      .i_raddr (i_prog_address),
      .o_rdata (o_instruction)
   );

   // Inter-byte gap counter, active only while a frame is being received.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo <= '0;
      end else if (w_in_frame && !i_rx_valid) begin
         r_tmo <= r_tmo + CNT_W'(1);
      end else begin
         r_tmo <= '0;
      end
   end

   // Loader FSM with registered status outputs and CPU enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cpu_en     <= 1'b0;
         r_loaded     <= 1'b0;
         r_word_count <= '0;
         r_error      <= 1'b0;
         r_waddr      <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT, ST_ERROR: begin
               if (i_rx_valid && (i_rx_data == START_BYTE)) begin
                  r_state  <= ST_LEN_HI;
                  r_error  <= 1'b0;
                  r_loaded <= 1'b0;
               end
            end
            ST_LEN_HI: begin
               if (i_rx_valid) begin
                  r_len_hi <= i_rx_data;
                  r_state  <= ST_LEN_LO;
               end else if (w_timeout) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
               end
            end
            ST_LEN_LO: begin
               if (i_rx_valid) begin
                  if ((w_len == 16'd0) || (w_len > MAX_N)) begin
                     r_state <= ST_ERROR;
                     r_error <= 1'b1;
                  end else begin
                     r_waddr <= '0;
                     r_last  <= ADDR_W'(w_len - 16'd1);
                     r_len_n <= WC_W'(w_len);
                     r_state <= ST_DATA_HI;
                  end
               end else if (w_timeout) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
               end
            end
            ST_DATA_HI: begin
               if (i_rx_valid) begin
                  r_hi    <= i_rx_data;
                  r_state <= ST_DATA_LO;
               end else if (w_timeout) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
               end
            end
            ST_DATA_LO: begin
               if (i_rx_valid) begin
                  if (r_waddr == r_last) begin
                     r_word_count <= r_len_n;
                     r_loaded     <= 1'b1;
                     r_cpu_en     <= 1'b1;
                     r_state      <= ST_RUN;
                  end else begin
                     r_waddr <= r_waddr + ADDR_W'(1);
                     r_state <= ST_DATA_HI;
                  end
               end else if (w_timeout) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
               end
            end
            ST_RUN: begin
               // Bytes are ignored here; done takes priority over any byte.
               if (i_bip_done) begin
                  r_state  <= ST_HALT;
                  r_cpu_en <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cpu_enable = r_cpu_en;
   assign o_loaded     = r_loaded;
   assign o_word_count = r_word_count;
   assign o_error      = r_error;

endmodule
